ddr2_req_arbiter: RTL
=====================

# ddr2_req_arbiter

Command-level arbiter in front of the DDR2 controller's user port. Shares the single burst interface between a write requester (pattern generator) and a read requester (read-back/checker). Schedules periodic auto-refresh with a bounded postponement debt. Sits between the test traffic sources and the controller core in `top1`, downstream of controller initialisation.

## Interface
- `ADDR_WIDTH`, 26: user address width (ROW 13 + COL 10 + BA 3).
- `REF_INTERVAL`, 780: sys_clk cycles between refresh obligations (7.8 us at 100 MHz).
- `REF_MAX_DEBT`, 8: maximum postponed refreshes (DDR2 limit).

- `sys_clk` in 1: single clock; all logic on rising edge.
- `sys_rst` in 1: synchronous, active-high reset.
- `init_end` in 1: controller initialisation complete; level.
- `wr_req` in 1: write burst request; held until `wr_grant`.
- `wr_addr` in ADDR_WIDTH: write burst start address; stable while `wr_req`.
- `wr_grant` out 1: one-cycle pulse, write command accepted by controller.
- `wr_done` out 1: one-cycle pulse, write burst completed.
- `rd_req`, `rd_addr`, `rd_grant`, `rd_done`: same as write set, for reads.
- `ctrl_cmd_valid` out 1: command presented to controller.
- `ctrl_cmd_ready` in 1: controller accepts command when high with valid.
- `ctrl_cmd` out 2: 2'b01 write, 2'b10 read, 2'b11 refresh, 2'b00 none.
- `ctrl_cmd_addr` out ADDR_WIDTH: burst address (0 for refresh).
- `ctrl_done` in 1: one-cycle pulse, current command finished.
- `ref_debt` out 4: outstanding refreshes.
- `ref_overrun` out 1: sticky, refresh expiry occurred at full debt.
- `busy` out 1: FSM not in IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT_DONE.
- Before `init_end`: FSM held in IDLE, refresh timer held at REF_INTERVAL-1, no commands issued, requests ignored.
- Refresh timer: counts down from REF_INTERVAL-1 once `init_end`; at 0 reloads and increments `ref_debt`. If `ref_debt` == REF_MAX_DEBT at expiry: saturates, `ref_overrun` set until reset.
- IDLE priority (evaluated every cycle): `ref_debt` != 0 -> refresh; else one of `wr_req`/`rd_req` -> that one; both -> round-robin, opposite of last granted data command (`last_wr` flag, reset value 0 so write wins first tie).
- IDLE -> ISSUE: latch command type and address (from `wr_addr`/`rd_addr`, 0 for refresh).
- ISSUE: `ctrl_cmd_valid`=1, `ctrl_cmd`/`ctrl_cmd_addr` stable until handshake. On `ctrl_cmd_valid & ctrl_cmd_ready` -> WAIT_DONE; refresh: `ref_debt` decrements; data: `last_wr` updated.
- WAIT_DONE: `ctrl_cmd_valid`=0, `ctrl_cmd`=00. On `ctrl_done` -> IDLE, pulse matching `wr_done`/`rd_done` (none for refresh).
- `ctrl_done` outside WAIT_DONE is ignored.
- Simultaneous timer expiry and refresh handshake: `ref_debt` unchanged.
- A requester dropping `req` before grant is legal only while arbiter is IDLE; once latched (ISSUE), command completes regardless.
- `init_end` falling mid-command: current command completes; no further issues.

## Timing
- Reset values: all outputs 0, `ctrl_cmd` 2'b00, `ctrl_cmd_addr` 0, `ref_debt` 0, `ref_overrun` 0, FSM IDLE, timer REF_INTERVAL-1, `last_wr` 0.
- Request seen in IDLE at cycle t -> `ctrl_cmd_valid` high at t+1.
- Handshake at cycle h -> `wr_grant`/`rd_grant` high at h+1 only (registered); requester deasserts `req` in h+1; arbiter is in WAIT_DONE so stale `req` in h+1 is not re-arbitrated.
- `ctrl_done` at d -> `*_done` pulse at d+1, FSM IDLE at d+1, next `ctrl_cmd_valid` earliest d+2.
- Minimum command-to-command spacing: 3 cycles + controller latency.
- Timer period exactly REF_INTERVAL cycles; first expiry REF_INTERVAL cycles after `init_end` rises.

## Test plan
- Single write: `init_end`=1, `wr_req` addr 0x0000123, ready tied 1, `ctrl_done` 10 cycles after handshake -> valid at t+1 with cmd 01 addr 0x0000123, `wr_grant` at h+1, `wr_done` at d+1, FSM IDLE.
- Contention: `wr_req` and `rd_req` held continuously, each re-asserted after grant -> grants alternate W,R,W,R for 8 commands.
- Refresh priority: REF_INTERVAL=20, continuous `wr_req` -> refresh (cmd 11, addr 0) issued at first IDLE after expiry ahead of write; `ref_debt` 1 -> 0 on handshake.
- Debt/overrun: REF_INTERVAL=20, `ctrl_cmd_ready` held 0 for 200 cycles -> `ref_debt` climbs to 8, saturates, `ref_overrun`=1; release ready -> 8 refreshes drain debt to 0, `ref_overrun` stays 1.
- Gating/reset: requests with `init_end`=0 -> no `ctrl_cmd_valid`; assert `sys_rst` during WAIT_DONE -> next cycle all outputs at reset values, later `ctrl_done` produces no `*_done`.

Source files
------------

// File: rtl/ddr2_req_arbiter.sv
// ddr2_req_arbiter: shares the DDR2 user command port between a write and a
// read requester, and schedules auto-refresh with a bounded postponement debt.
module ddr2_req_arbiter #(
    parameter int ADDR_WIDTH   = 26,
    parameter int REF_INTERVAL = 780,
    parameter int REF_MAX_DEBT = 8
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  init_end,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  wr_grant,
    output logic                  wr_done,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_grant,
    output logic                  rd_done,
    output logic                  ctrl_cmd_valid,
    input  logic                  ctrl_cmd_ready,
    output logic [1:0]            ctrl_cmd,
    output logic [ADDR_WIDTH-1:0] ctrl_cmd_addr,
    input  logic                  ctrl_done,
    output logic [3:0]            ref_debt,
    output logic                  ref_overrun,
    output logic                  busy
);

    localparam int TW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(REF_INTERVAL - 1);
    localparam logic [3:0]    DEBT_MAX   = 4'(REF_MAX_DEBT);

    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_WR   = 2'b01;
    localparam logic [1:0] CMD_RD   = 2'b10;
    localparam logic [1:0] CMD_REF  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } state_t;

    state_t                state, state_nxt;
    logic [1:0]            cmd_q, cmd_nxt;
    logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
    logic [TW-1:0]         timer;
    logic                  last_wr;
    logic                  hs;
    logic                  ref_hs;
    logic                  expire;

    assign hs     = (state == ISSUE) && ctrl_cmd_ready;
    assign ref_hs = hs && (cmd_q == CMD_REF);
    assign expire = init_end && (timer == '0);

    assign ctrl_cmd_valid = (state == ISSUE);
    assign ctrl_cmd       = ctrl_cmd_valid ? cmd_q : CMD_NONE;
    assign ctrl_cmd_addr  = ctrl_cmd_valid ? addr_q : '0;
    assign busy           = (state != IDLE);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state  <= IDLE;
            cmd_q  <= CMD_NONE;
            addr_q <= '0;
        end else begin
            state  <= state_nxt;
            cmd_q  <= cmd_nxt;
            addr_q <= addr_nxt;
        end
    end

    // Refresh wins; on a data tie, serve the side not granted last.
    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd_q;
        addr_nxt  = addr_q;
        case (state)
            IDLE: begin
                if (init_end) begin
                    if (ref_debt != 4'd0) begin
                        state_nxt = ISSUE;
                        cmd_nxt   = CMD_REF;
                        addr_nxt  = '0;
                    end else if (wr_req && !(rd_req && last_wr)) begin
                        state_nxt = ISSUE;
                        cmd_nxt   = CMD_WR;
                        addr_nxt  = wr_addr;
                    end else if (rd_req) begin
                        state_nxt = ISSUE;
                        cmd_nxt   = CMD_RD;
                        addr_nxt  = rd_addr;
                    end
                end
            end
            ISSUE: begin
                if (ctrl_cmd_ready) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (ctrl_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_grant <= 1'b0;
            rd_grant <= 1'b0;
            wr_done  <= 1'b0;
            rd_done  <= 1'b0;
            last_wr  <= 1'b0;
        end else begin
            wr_grant <= hs && (cmd_q == CMD_WR);
            rd_grant <= hs && (cmd_q == CMD_RD);
            wr_done  <= (state == WAIT_DONE) && ctrl_done && (cmd_q == CMD_WR);
            rd_done  <= (state == WAIT_DONE) && ctrl_done && (cmd_q == CMD_RD);
            if (hs && (cmd_q == CMD_WR)) begin
                last_wr <= 1'b1;
            end else if (hs && (cmd_q == CMD_RD)) begin
                last_wr <= 1'b0;
            end
        end
    end

    // An expiry that coincides with a refresh handshake cancels out.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            timer       <= TIMER_LOAD;
            ref_debt    <= 4'd0;
            ref_overrun <= 1'b0;
        end else begin
            if (!init_end || timer == '0) begin
                timer <= TIMER_LOAD;
            end else begin
                timer <= timer - TW'(1);
            end
            if (expire && !ref_hs) begin
                if (ref_debt == DEBT_MAX) begin
                    ref_overrun <= 1'b1;
                end else begin
                    ref_debt <= ref_debt + 4'd1;
                end
            end else if (ref_hs && !expire) begin
                ref_debt <= ref_debt - 4'd1;
            end
        end
    end

endmodule
